// File: rtl/sap_pkg.sv
// Shared constants for the SAP core: opcodes, machine states, microstep sizing.
package sap_pkg;

  localparam int STEP_W = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Final microstep of each instruction; fetch is T0/T1 for all of them.
  localparam logic [STEP_W-1:0] LAST_SHORT = 3'd2;
  localparam logic [STEP_W-1:0] LAST_MEM   = 3'd3;
  localparam logic [STEP_W-1:0] LAST_ALU   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Undefined opcodes fall into the short (NOP-like) class.
  function automatic logic [STEP_W-1:0] last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: last_step = LAST_MEM;
      OP_ADD, OP_SUB: last_step = LAST_ALU;
      default:        last_step = LAST_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM: one synchronous write port, one asynchronous read port.
module sap_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write on the clock edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_core_p.sv
// SAP computer core: fetch/execute microsequencer, A/B/flags, output register,
// with an external program-load port sharing the RAM write port.
module sap_core_p
  import sap_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic          carry_flag,
  output logic          zero_flag
);

  state_t              state, state_nx;
  logic [STEP_W-1:0]   step;
  logic [AW-1:0]       mar;
  logic [DW-1:0]       ir, a, b;
  logic [DW-1:0]       ram_rdata;
  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [DW-1:0]       ram_wdata;
  logic [3:0]          op;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       imm;
  logic [DW:0]         alu;
  logic                run, start_ok, exec;

  assign op       = ir[DW-1:DW-4];
  assign addr     = ir[AW-1:0];
  assign imm      = {4'b0, ir[DW-5:0]};
  assign run      = (state == ST_RUN);
  assign start_ok = start && !run;
  assign exec     = run && (step >= 3'd2);
  assign busy     = run;
  assign halted   = (state == ST_HALT);

  // Add, or subtract as A + ~B + 1 so the carry out means "no borrow".
  assign alu = (op == OP_SUB) ? ({1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1})
                              : ({1'b0, a} + {1'b0, b});

  // RAM write port belongs to the loader outside RUN and to STA T3 inside it.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = prog_addr;
    ram_wdata = prog_data;
    if (!run) begin
      ram_we = prog_we;
    end else if (op == OP_STA && step == 3'd3) begin
      ram_we    = 1'b1;
      ram_waddr = mar;
      ram_wdata = a;
    end
  end

  sap_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar),
    .rdata (ram_rdata)
  );

  // Machine state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: start leaves IDLE/HALT, HLT T2 leaves RUN.
  always_comb begin
    state_nx = state;
    if (start_ok)
      state_nx = ST_RUN;
    else if (exec && step == 3'd2 && op == OP_HLT)
      state_nx = ST_HALT;
  end

  // Microsequenced datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      step       <= '0;
    end else begin
      out_valid <= 1'b0;
      if (start_ok) begin
        pc   <= '0;
        step <= '0;
      end else if (run) begin
        case (step)
          3'd0: begin
            mar  <= pc;
            step <= 3'd1;
          end
          3'd1: begin
            ir   <= ram_rdata;
            pc   <= pc + 1'b1;
            step <= 3'd2;
          end
          default: begin
            step <= (step == last_step(op)) ? '0 : step + 1'b1;
            case (op)
              OP_LDA, OP_STA: begin
                if (step == 3'd2) mar <= addr;
                if (step == 3'd3 && op == OP_LDA) a <= ram_rdata;
              end
              OP_ADD, OP_SUB: begin
                if (step == 3'd2) mar <= addr;
                if (step == 3'd3) b <= ram_rdata;
                if (step == 3'd4) begin
                  a          <= alu[DW-1:0];
                  carry_flag <= alu[DW];
                  zero_flag  <= (alu[DW-1:0] == '0);
                end
              end
              OP_LDI: a  <= imm;
              OP_JMP: pc <= addr;
              OP_JC:  if (carry_flag) pc <= addr;
              OP_JZ:  if (zero_flag)  pc <= addr;
              OP_OUT: begin
                out       <= a;
                out_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap_core_p.sv
// Directed bench for sap_core_p: small programs with hand-computed results.
module tb_sap_core_p;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [DW-1:0] out;
  logic          out_valid, busy, halted, carry_flag, zero_flag;
  logic [AW-1:0] pc;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] img [16];
  logic [DW-1:0] outs [$];

  sap_core_p #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_img();
    for (int i = 0; i < 16; i++) img[i] = '0;
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = img[i];
      tick(1);
    end
    prog_we = 1'b0;
  endtask

  // Leaves time 1ns after the start edge.
  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int n;
    n = 0;
    outs.delete();
    while (!halted && n < 400) begin
      tick(1);
      if (out_valid) outs.push_back(out);
      n++;
    end
    chk({tag, "_halt"}, halted, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #12;
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_flags", {carry_flag, zero_flag, out_valid}, 0);
    reset = 1'b0;
    tick(1);

    // Add and output
    clr_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'h42; img[15] = 8'h1E;
    load_img();
    go();
    tick(11);
    chk("add_ov_pre", out_valid, 0);
    tick(1);
    chk("add_out", out, 8'h60);
    chk("add_ov", out_valid, 1);
    tick(1);
    chk("add_ov_drop", out_valid, 0);
    tick(1);
    chk("add_not_halt", halted, 0);
    tick(1);
    chk("add_halted", halted, 1);
    chk("add_busy", busy, 0);
    chk("add_cz", {carry_flag, zero_flag}, 2'b00);

    // Countdown loop
    clr_img();
    img[0] = 8'h53; img[1] = 8'h3F; img[2] = 8'hE0; img[3] = 8'h85;
    img[4] = 8'h61; img[5] = 8'hF0; img[15] = 8'h01;
    load_img();
    go();
    run_to_halt("cd");
    chk("cd_n", outs.size(), 3);
    if (outs.size() == 3) begin
      chk("cd_o0", outs[0], 8'h02);
      chk("cd_o1", outs[1], 8'h01);
      chk("cd_o2", outs[2], 8'h00);
    end
    chk("cd_cz", {carry_flag, zero_flag}, 2'b11);

    // Store and reload
    clr_img();
    img[0] = 8'h59; img[1] = 8'h4D; img[2] = 8'h1D; img[3] = 8'hE0; img[4] = 8'hF0;
    load_img();
    go();
    run_to_halt("st");
    chk("st_out", out, 8'h09);
    chk("st_mem", dut.u_ram.mem[13], 8'h09);
    go();
    tick(9);
    chk("st_busy", busy, 1);
    prog_we = 1'b1; prog_addr = 4'hD; prog_data = 8'h77;
    tick(1);
    prog_we = 1'b0;
    chk("st_we_run", dut.u_ram.mem[13], 8'h09);
    run_to_halt("st2");
    chk("st2_out", out, 8'h09);

    // Overflow and branch
    clr_img();
    img[0] = 8'h5F; img[1] = 8'h2E; img[2] = 8'h75; img[3] = 8'hE0;
    img[4] = 8'hF0; img[5] = 8'hF0; img[14] = 8'hF5;
    load_img();
    go();
    run_to_halt("ov");
    chk("ov_a", dut.a, 8'h04);
    chk("ov_c", carry_flag, 1);
    chk("ov_z", zero_flag, 0);
    chk("ov_nout", outs.size(), 0);
    chk("ov_pc", pc, 4'h6);

    // Reset during ADD T3 (step 3 is live after the 7th edge)
    clr_img();
    img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'hE0; img[3] = 8'hF0;
    img[14] = 8'h42; img[15] = 8'h1E;
    load_img();
    go();
    tick(7);
    #2 reset = 1'b1;
    #1;
    chk("mr_out", out, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pc", pc, 0);
    chk("mr_misc", {halted, out_valid, carry_flag, zero_flag}, 0);
    chk("mr_a", dut.a, 0);
    chk("mr_memE", dut.u_ram.mem[14], 8'h42);
    chk("mr_memF", dut.u_ram.mem[15], 8'h1E);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    go();
    tick(12);
    chk("mr_rerun_out", out, 8'h60);
    chk("mr_rerun_ov", out_valid, 1);
    run_to_halt("mr");

    // PC wrap over an all-NOP RAM
    clr_img();
    load_img();
    go();
    tick(2);
    chk("wr_pc1", pc, 4'h1);
    tick(44);
    chk("wr_pcF", pc, 4'hF);
    tick(1);
    chk("wr_pc0", pc, 4'h0);
    tick(2);
    chk("wr_pc49", pc, 4'h0);
    chk("wr_busy", busy, 1);
    chk("wr_halted", halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
